// File: rtl/counter_timer_nch.sv
// Purpose: N-channel programmable down-counter/timer with per-channel tick enable, four modes, read-back and IRQ.
// Latency: bus writes take effect on the next clk edge; read data (counter_out) is registered, 1 cycle after counter_ch.
// Backpressure: none; the bus is always accepted, and a write to a channel overrides that channel's tick in the same cycle.
module counter_timer_nch #(
    parameter int NCH = 3,
    parameter int W   = 32,
    parameter int AW  = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] cnt_tick,
    input  logic           counter_we,
    input  logic [AW:0]    counter_ch,
    input  logic [W-1:0]   counter_val,
    output logic [W-1:0]   counter_out,
    output logic [NCH-1:0] counter_OUT,
    output logic           counter_irq
);

    typedef enum logic [1:0] {
        M_ONESHOT  = 2'b00,
        M_PERIODIC = 2'b01,
        M_SQUARE   = 2'b10,
        M_FREE     = 2'b11
    } mode_t;

    logic [W-1:0]   load_q  [NCH];
    logic [W-1:0]   load_d  [NCH];
    logic [W-1:0]   count_q [NCH];
    logic [W-1:0]   count_d [NCH];
    mode_t          mode_q  [NCH];
    mode_t          mode_d  [NCH];
    logic [NCH-1:0] en_q, en_d;
    logic [NCH-1:0] irq_en_q, irq_en_d;
    logic [NCH-1:0] irq_pend_q, irq_pend_d;
    logic [NCH-1:0] out_q, out_d;
    logic [NCH-1:0] irq_set, irq_clr;
    logic [W-1:0]   rd_q, rd_d;

    logic           ch_ctrl;
    logic [AW-1:0]  ch_idx;

    assign ch_ctrl = counter_ch[AW];
    assign ch_idx  = counter_ch[AW-1:0];

    // Value a channel restarts from: half period for square wave (clamped to 1),
    // the load value otherwise; a zero load keeps the channel idle at 0.
    function automatic logic [W-1:0] restart_val(input mode_t m, input logic [W-1:0] l);
        logic [W-1:0] h;
        h = l >> 1;
        if (h == '0) begin
            h = W'(1);
        end
        if (m == M_SQUARE && l != '0) begin
            return h;
        end
        return l;
    endfunction

    // Per-channel next state: bus write first, otherwise an enabled tick advances the mode.
    always_comb begin
        load_d  = load_q;
        count_d = count_q;
        mode_d  = mode_q;
        en_d     = en_q;
        irq_en_d = irq_en_q;
        out_d    = out_q;
        irq_set  = '0;
        irq_clr  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (counter_we && ch_idx == AW'(i)) begin
                out_d[i] = 1'b0;
                if (ch_ctrl) begin
                    en_d[i]     = counter_val[0];
                    mode_d[i]   = mode_t'(counter_val[2:1]);
                    irq_en_d[i] = counter_val[3];
                    irq_clr[i]  = counter_val[4];
                    count_d[i]  = restart_val(mode_t'(counter_val[2:1]), load_q[i]);
                end else begin
                    load_d[i]  = counter_val;
                    count_d[i] = restart_val(mode_q[i], counter_val);
                end
            end else begin
                // Periodic output is a single-clock pulse.
                if (mode_q[i] == M_PERIODIC) begin
                    out_d[i] = 1'b0;
                end
                if (cnt_tick[i] && en_q[i]) begin
                    case (mode_q[i])
                        M_ONESHOT: begin
                            if (count_q[i] > W'(1)) begin
                                count_d[i] = count_q[i] - W'(1);
                            end else if (count_q[i] == W'(1)) begin
                                count_d[i] = '0;
                                out_d[i]   = 1'b1;
                                irq_set[i] = 1'b1;
                            end
                        end
                        M_PERIODIC: begin
                            if (count_q[i] > W'(1)) begin
                                count_d[i] = count_q[i] - W'(1);
                            end else if (count_q[i] == W'(1)) begin
                                count_d[i] = load_q[i];
                                out_d[i]   = 1'b1;
                                irq_set[i] = 1'b1;
                            end
                        end
                        M_SQUARE: begin
                            if (count_q[i] > W'(1)) begin
                                count_d[i] = count_q[i] - W'(1);
                            end else if (count_q[i] == W'(1)) begin
                                count_d[i] = restart_val(M_SQUARE, load_q[i]);
                                out_d[i]   = ~out_q[i];
                                irq_set[i] = out_q[i];
                            end
                        end
                        default: begin
                            count_d[i] = count_q[i] - W'(1);
                            out_d[i]   = count_d[i][W-1];
                            irq_set[i] = (count_q[i] == '0);
                        end
                    endcase
                end
            end
        end
        // A set in the same cycle as a clear wins.
        irq_pend_d = (irq_pend_q & ~irq_clr) | irq_set;
    end

    // Read-back mux; unpopulated channel indices read as zero.
    always_comb begin
        rd_d = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ch_idx == AW'(i)) begin
                rd_d = ch_ctrl ? W'({irq_pend_q[i], irq_en_q[i], mode_q[i], en_q[i]}) : count_q[i];
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                load_q[i]  <= '0;
                count_q[i] <= '0;
                mode_q[i]  <= M_ONESHOT;
            end
            en_q       <= '0;
            irq_en_q   <= '0;
            irq_pend_q <= '0;
            out_q      <= '0;
            rd_q       <= '0;
        end else begin
            load_q     <= load_d;
            count_q    <= count_d;
            mode_q     <= mode_d;
            en_q       <= en_d;
            irq_en_q   <= irq_en_d;
            irq_pend_q <= irq_pend_d;
            out_q      <= out_d;
            rd_q       <= rd_d;
        end
    end

    assign counter_out = rd_q;
    assign counter_OUT = out_q;
    assign counter_irq = |(irq_pend_q & irq_en_q);

endmodule
